// File: rtl/chart_player_pkg.sv
// rtl/chart_player_pkg.sv - shared state encoding and chart word layout for chart_player
package chart_player_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SHOW  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int WORD_W  = 13;
  localparam int NOTE_HI = 12;
  localparam int NOTE_LO = 8;
  localparam int GAP_HI  = 7;
  localparam int GAP_LO  = 0;

  // A zero gap marks the end of the chart; the notes field is ignored.
  function automatic logic is_end_marker(input logic [WORD_W-1:0] word);
    return word[GAP_HI:GAP_LO] == '0;
  endfunction

endpackage

// File: rtl/chart_player_if.sv
// rtl/chart_player_if.sv - control, chart ROM and expected-note signals of chart_player
interface chart_player_if #(parameter int ADDR_W = 8);

  logic              start;
  logic              pause;
  logic              stop;
  logic [ADDR_W-1:0] rom_addr;
  logic [12:0]       rom_data;
  logic [4:0]        exp_notes;
  logic              playing;
  logic              song_done;
  logic [7:0]        notes_played;

  modport master (
    input  start, pause, stop, rom_data,
    output rom_addr, exp_notes, playing, song_done, notes_played
  );

  modport slave (
    output start, pause, stop, rom_data,
    input  rom_addr, exp_notes, playing, song_done, notes_played
  );

endinterface

// File: rtl/chart_player_tick_prescaler.sv
// rtl/chart_player_tick_prescaler.sv - divides clk into one-cycle chart ticks while enabled
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/chart_player.sv
// rtl/chart_player.sv - walks the chart ROM and presents each chord on exp_notes for its hit window
module chart_player
  import chart_player_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int HIT_WINDOW = 8,
  parameter int ADDR_W     = 8
) (
  input  logic           clk,
  input  logic           resetn,
  chart_player_if.master bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [4:0]        exp_notes_q;
  logic              playing_q;
  logic              song_done_q;
  logic [7:0]        notes_played_q;
  logic [7:0]        tick_cnt_q;
  logic [7:0]        show_q;
  logic [7:0]        gap_left_q;

  logic [4:0] rom_notes;
  logic [7:0] rom_gap;
  logic [7:0] gap_m1;
  logic [7:0] show_d;
  logic [7:0] phase_len;
  logic       tick;
  logic       phase_end;
  logic       pre_en;
  logic       pre_clr;

  assign rom_notes = bus.rom_data[NOTE_HI:NOTE_LO];
  assign rom_gap   = bus.rom_data[GAP_HI:GAP_LO];
  assign gap_m1    = rom_gap - 8'd1;
  assign show_d    = (32'(gap_m1) < HIT_WINDOW) ? gap_m1 : 8'(HIT_WINDOW);

  assign phase_len = (state_q == S_SHOW) ? show_q : gap_left_q;
  assign phase_end = tick && (tick_cnt_q == phase_len - 8'd1);

  // Clear on the edge that enters SHOW or GAP so every phase starts on a fresh tick.
  assign pre_en  = (state_q == S_SHOW || state_q == S_GAP) && !bus.pause && !bus.stop;
  assign pre_clr = bus.stop ||
                   (!bus.pause && (state_q == S_WAIT || (state_q == S_SHOW && phase_end)));

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .en     (pre_en),
    .clr    (pre_clr),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      rom_addr_q     <= '0;
      exp_notes_q    <= '0;
      playing_q      <= 1'b0;
      song_done_q    <= 1'b0;
      notes_played_q <= '0;
      tick_cnt_q     <= '0;
      show_q         <= '0;
      gap_left_q     <= '0;
    end else if (bus.stop) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      exp_notes_q <= '0;
      playing_q   <= 1'b0;
      song_done_q <= 1'b0;
      tick_cnt_q  <= '0;
    end else if (!bus.pause) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q        <= S_FETCH;
            rom_addr_q     <= '0;
            notes_played_q <= '0;
            playing_q      <= 1'b1;
            song_done_q    <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          tick_cnt_q <= '0;
          if (is_end_marker(bus.rom_data)) begin
            state_q     <= S_DONE;
            exp_notes_q <= '0;
            playing_q   <= 1'b0;
            song_done_q <= 1'b1;
          end else if (show_d != 8'd0 && rom_notes != 5'd0) begin
            state_q     <= S_SHOW;
            exp_notes_q <= rom_notes;
            show_q      <= show_d;
            gap_left_q  <= rom_gap - show_d;
            if (notes_played_q != 8'hFF) notes_played_q <= notes_played_q + 8'd1;
          end else begin
            state_q     <= S_GAP;
            exp_notes_q <= '0;
            gap_left_q  <= rom_gap;
          end
        end
        S_SHOW: begin
          if (phase_end) begin
            state_q     <= S_GAP;
            exp_notes_q <= '0;
            tick_cnt_q  <= '0;
          end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + 8'd1;
          end
        end
        S_GAP: begin
          if (phase_end) begin
            tick_cnt_q <= '0;
            // The last ROM entry ends the song even without an end marker.
            if (rom_addr_q == '1) begin
              state_q     <= S_DONE;
              playing_q   <= 1'b0;
              song_done_q <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              rom_addr_q <= rom_addr_q + 1'b1;
            end
          end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr     = rom_addr_q;
  assign bus.exp_notes    = exp_notes_q;
  assign bus.playing      = playing_q;
  assign bus.song_done    = song_done_q;
  assign bus.notes_played = notes_played_q;

endmodule
